mod_dp: RTL and testbench

Datapath partner of the repeated-subtraction modulo controller. It responds to the controller's `save_A` / `subtract` strobes and returns the `less_than_B` status. It holds the working remainder, a latched divisor and an optional quotient count. It also flags divide-by-zero and protocol misuse so the control loop always terminates.

---
 rtl/mod_dp.sv | 93 +++++++++
 tb/tb_mod_dp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mod_dp.sv
// mod_dp: repeated-subtraction modulo datapath (remainder, divisor, flags).
// Optional quotient counter enabled by defining MOD_DP_QUOTIENT_EN.
module mod_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             save_A,
  input  logic             subtract,
  output logic             less_than_B,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero,
  output logic             sub_err
);

  logic [WIDTH-1:0] temp_q, temp_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             dz_q, dz_d;
  logic             serr_q, serr_d;
  logic             do_sub;

  // Status comes from registers only; a zero divisor forces loop exit.
  assign less_than_B = (temp_q < b_q) | dz_q;

  // A legal subtract: not loading and the remainder still covers B.
  assign do_sub = ~save_A & subtract & ~less_than_B;

  // Next-state: load beats subtract; misuse only raises the error flag.
  always_comb begin
    temp_d = temp_q;
    b_d    = b_q;
    dz_d   = dz_q;
    serr_d = serr_q;
    if (save_A) begin
      temp_d = A;
      b_d    = B;
      dz_d   = (B == '0);
      serr_d = 1'b0;
    end else if (subtract && less_than_B) begin
      serr_d = 1'b1;
    end else if (do_sub) begin
      temp_d = temp_q - b_q;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      temp_q <= '0;
      b_q    <= '0;
      dz_q   <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      temp_q <= temp_d;
      b_q    <= b_d;
      dz_q   <= dz_d;
      serr_q <= serr_d;
    end
  end

`ifdef MOD_DP_QUOTIENT_EN
  logic [WIDTH-1:0] quot_q, quot_d;

  // Quotient clears on load and counts each legal subtraction.
  always_comb begin
    quot_d = quot_q;
    if (save_A)
      quot_d = '0;
    else if (do_sub)
      quot_d = quot_q + 1'b1;
  end

  // Quotient register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      quot_q <= '0;
    else
      quot_q <= quot_d;
  end

  assign quotient = quot_q;
`else
  assign quotient = '0;
`endif

  assign remainder   = temp_q;
  assign div_by_zero = dz_q;
  assign sub_err     = serr_q;

endmodule

// File: tb/tb_mod_dp.sv
// tb_mod_dp: directed and randomized checks of mod_dp against
// a division-level reference (A/B, A%B) computed in the bench.
module tb_mod_dp;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         save_A = 1'b0;
  logic         subtract = 1'b0;
  logic         less_than_B;
  logic [W-1:0] remainder;
  logic [W-1:0] quotient;
  logic         div_by_zero;
  logic         sub_err;

  int total = 0;
  int bad = 0;

  mod_dp #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .A          (A),
    .B          (B),
    .save_A     (save_A),
    .subtract   (subtract),
    .less_than_B(less_than_B),
    .remainder  (remainder),
    .quotient   (quotient),
    .div_by_zero(div_by_zero),
    .sub_err    (sub_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] qx(input logic [W-1:0] v);
`ifdef MOD_DP_QUOTIENT_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic load(input logic [W-1:0] a,
                      input logic [W-1:0] b);
    A = a;
    B = b;
    save_A = 1'b1;
    @(negedge clk);
    save_A = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  // Hold subtract while less_than_B is low; return cycles spent.
  task automatic spin(output int n);
    n = 0;
    while (!less_than_B && n < 5000) begin
      subtract = 1'b1;
      @(negedge clk);
      n++;
    end
    subtract = 1'b0;
  endtask

  task automatic extra_subs(input int k);
    for (int i = 0; i < k; i++) begin
      subtract = 1'b1;
      @(negedge clk);
    end
    subtract = 1'b0;
  endtask

  task automatic run_div(input string tag,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    int n;
    logic [W-1:0] eq, er;
    eq = (b == 0) ? '0 : a / b;
    er = (b == 0) ? a : a % b;
    load(a, b);
    spin(n);
    chk({tag, "_cycles"}, W'(n), eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_quot"}, quotient, qx(eq));
    chk({tag, "_dz"}, W'(div_by_zero), W'(b == 0));
    chk({tag, "_serr"}, W'(sub_err), '0);
    chk({tag, "_lt"}, W'(less_than_B), 1);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb, eq;
    int k;

    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rem", remainder, '0);
    chk("rst_quot", quotient, '0);
    chk("rst_dz", W'(div_by_zero), '0);
    chk("rst_serr", W'(sub_err), '0);
    chk("rst_lt", W'(less_than_B), '0);

    run_div("d17_5", 17, 5);

    extra_subs(2);
    chk("mis_rem", remainder, 2);
    chk("mis_quot", quotient, qx(3));
    chk("mis_serr", W'(sub_err), 1);
    load(10, 3);
    chk("clr_serr", W'(sub_err), '0);
    chk("clr_rem", remainder, 10);

    run_div("d3_7", 3, 7);

    load(42, 0);
    chk("dz_flag", W'(div_by_zero), 1);
    chk("dz_lt", W'(less_than_B), 1);
    chk("dz_rem", remainder, 42);
    extra_subs(1);
    chk("dz_serr", W'(sub_err), 1);
    chk("dz_rem2", remainder, 42);

    load(100, 7);
    extra_subs(1);
    A = 9;
    B = 4;
    save_A = 1'b1;
    subtract = 1'b1;
    @(negedge clk);
    save_A = 1'b0;
    subtract = 1'b0;
    chk("both_rem", remainder, 9);
    chk("both_quot", quotient, '0);
    chk("both_lt", W'(less_than_B), '0);

    load(100, 1);
    extra_subs(50);
    chk("r50_rem", remainder, 50);
    chk("r50_quot", quotient, qx(50));
    #2 reset_n = 1'b0;
    #1;
    chk("ar_rem", remainder, '0);
    chk("ar_quot", quotient, '0);
    chk("ar_lt", W'(less_than_B), '0);
    chk("ar_dz", W'(div_by_zero), '0);
    chk("ar_serr", W'(sub_err), '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_lt", W'(less_than_B), '0);
    chk("rel_rem", remainder, '0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 600));
      rb = ($urandom_range(0, 7) == 0) ? '0
           : W'($urandom_range(1, 40));
      if (i == 0) ra = W'($urandom);
      if (i == 0) rb = (ra >> 4) + 1;
      eq = (rb == 0) ? '0 : ra / rb;
      load(ra, rb);
      spin(n);
      chk("rnd_cycles", W'(n), eq);
      chk("rnd_rem", remainder, (rb == 0) ? ra : ra % rb);
      chk("rnd_quot", quotient, qx(eq));
      chk("rnd_dz", W'(div_by_zero), W'(rb == 0));
      k = $urandom_range(0, 2);
      extra_subs(k);
      chk("rnd_serr", W'(sub_err), W'(k > 0));
      chk("rnd_hold", remainder, (rb == 0) ? ra : ra % rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
